// File: rtl/dacobuf_seq.sv
// DAC output buffer segment sequencer: table of {start, stop, rep, last} entries
// driving the buffer port-B read address with chaining, repeats and looping.
// Build option: define DACOBUF_SEQ_TRIG_EN to add an ARM state that waits for trig_i.
`timescale 1ns/1ps

// Purpose: walk the segment table and emit one buffer read address per cycle.
// Latency: first address one cycle after start_i (or after trig_i in ARM); no bubble between segments.
// Backpressure: none; the RAM is read every cycle, stop_i aborts on the next cycle.
module dacobuf_seq #(
  parameter int DACBUF_SIZE = 8,
  parameter int NSEG        = 4,
  parameter int SEG_IW      = 2,
  parameter int REP_W       = 8
) (
  input  logic                   dac_refclk_i,
  input  logic                   up_rst,
  input  logic                   seg_wr_en,
  input  logic [SEG_IW-1:0]      seg_wr_idx,
  input  logic [DACBUF_SIZE:0]   seg_wr_start,
  input  logic [DACBUF_SIZE:0]   seg_wr_stop,
  input  logic [REP_W-1:0]       seg_wr_rep,
  input  logic                   seg_wr_last,
  input  logic                   loop_en,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   trig_i,
  output logic [DACBUF_SIZE:0]   rd_addr_o,
  output logic                   rd_valid_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [SEG_IW-1:0]      cur_seg_o
);

  localparam int AW = DACBUF_SIZE + 1;
  localparam logic [SEG_IW-1:0] LAST_IDX = SEG_IW'(NSEG - 1);
  localparam logic [AW-1:0]     ADDR_ONE = {{DACBUF_SIZE{1'b0}}, 1'b1};
  localparam logic [REP_W-1:0]  REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
`ifdef DACOBUF_SEQ_TRIG_EN
    S_ARM  = 2'd2,
`endif
    S_IDLE = 2'd0,
    S_PLAY = 2'd1
  } state_t;

  state_t state_q, state_d;

  // Segment table
  logic [AW-1:0]    tbl_start [NSEG];
  logic [AW-1:0]    tbl_stop  [NSEG];
  logic [REP_W-1:0] tbl_rep   [NSEG];
  logic             tbl_last  [NSEG];

  // Working copy of the active segment, frozen at load time
  logic [AW-1:0]     addr_q, start_q, stop_q;
  logic [REP_W-1:0]  rep_q, rep_cnt_q;
  logic              last_q;
  logic [SEG_IW-1:0] seg_q;
  logic              vld_q, busy_q, done_q;

  // Next-step decisions from the FSM
  logic              ld;
  logic [SEG_IW-1:0] ld_idx;
  logic              adv;
  logic              rpt;
  logic              fin;

`ifndef DACOBUF_SEQ_TRIG_EN
  logic unused_trig;
  assign unused_trig = trig_i;
`endif

  // Table write port; the new entry is visible from the following cycle
  always_ff @(posedge dac_refclk_i or posedge up_rst) begin
    if (up_rst) begin
      for (int i = 0; i < NSEG; i++) begin
        tbl_start[i] <= '0;
        tbl_stop[i]  <= '0;
        tbl_rep[i]   <= '0;
        tbl_last[i]  <= 1'b0;
      end
    end else if (seg_wr_en) begin
      tbl_start[seg_wr_idx] <= seg_wr_start;
      tbl_stop[seg_wr_idx]  <= seg_wr_stop;
      tbl_rep[seg_wr_idx]   <= seg_wr_rep;
      tbl_last[seg_wr_idx]  <= seg_wr_last;
    end
  end

  // State register
  always_ff @(posedge dac_refclk_i or posedge up_rst) begin
    if (up_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle action select; stop_i outranks every other event
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_idx  = '0;
    adv     = 1'b0;
    rpt     = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!stop_i && start_i) begin
`ifdef DACOBUF_SEQ_TRIG_EN
          state_d = S_ARM;
`else
          state_d = S_PLAY;
          ld      = 1'b1;
`endif
        end
      end
`ifdef DACOBUF_SEQ_TRIG_EN
      S_ARM: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (trig_i) begin
          state_d = S_PLAY;
          ld      = 1'b1;
        end
      end
`endif
      S_PLAY: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (addr_q != stop_q) begin
          adv = 1'b1;
        end else if (rep_cnt_q < rep_q) begin
          rpt = 1'b1;
        end else if (!last_q && (seg_q != LAST_IDX)) begin
          ld     = 1'b1;
          ld_idx = seg_q + 1'b1;
        end else if (loop_en) begin
          ld = 1'b1;
        end else begin
          fin     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address generator and registered outputs
  always_ff @(posedge dac_refclk_i or posedge up_rst) begin
    if (up_rst) begin
      addr_q    <= '0;
      start_q   <= '0;
      stop_q    <= '0;
      rep_q     <= '0;
      rep_cnt_q <= '0;
      last_q    <= 1'b0;
      seg_q     <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= fin;
      busy_q <= (state_d != S_IDLE);
      if (state_d != S_PLAY) begin
        addr_q <= '0;
        vld_q  <= 1'b0;
        seg_q  <= '0;
      end else if (ld) begin
        addr_q    <= tbl_start[ld_idx];
        start_q   <= tbl_start[ld_idx];
        stop_q    <= tbl_stop[ld_idx];
        rep_q     <= tbl_rep[ld_idx];
        last_q    <= tbl_last[ld_idx];
        rep_cnt_q <= '0;
        seg_q     <= ld_idx;
        vld_q     <= 1'b1;
      end else if (adv) begin
        addr_q <= addr_q + ADDR_ONE;
      end else if (rpt) begin
        addr_q    <= start_q;
        rep_cnt_q <= rep_cnt_q + REP_ONE;
      end
    end
  end

  assign rd_addr_o  = addr_q;
  assign rd_valid_o = vld_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cur_seg_o  = seg_q;

endmodule

// File: tb/tb_dacobuf_seq.sv
// Directed bench for dacobuf_seq with an expected-output scoreboard.
`timescale 1ns/1ps

module tb_dacobuf_seq;

  localparam int DS   = 8;
  localparam int NSEG = 4;
  localparam int SIW  = 2;
  localparam int RW   = 8;
  localparam int AMOD = 1 << (DS + 1);

  logic            clk = 1'b0;
  logic            up_rst;
  logic            seg_wr_en;
  logic [SIW-1:0]  seg_wr_idx;
  logic [DS:0]     seg_wr_start, seg_wr_stop;
  logic [RW-1:0]   seg_wr_rep;
  logic            seg_wr_last;
  logic            loop_en, start_i, stop_i, trig_i;
  logic [DS:0]     rd_addr_o;
  logic            rd_valid_o, busy_o, done_o;
  logic [SIW-1:0]  cur_seg_o;

  always #5 clk = ~clk;

  dacobuf_seq #(.DACBUF_SIZE(DS), .NSEG(NSEG), .SEG_IW(SIW), .REP_W(RW)) dut (
    .dac_refclk_i (clk),
    .up_rst       (up_rst),
    .seg_wr_en    (seg_wr_en),
    .seg_wr_idx   (seg_wr_idx),
    .seg_wr_start (seg_wr_start),
    .seg_wr_stop  (seg_wr_stop),
    .seg_wr_rep   (seg_wr_rep),
    .seg_wr_last  (seg_wr_last),
    .loop_en      (loop_en),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .trig_i       (trig_i),
    .rd_addr_o    (rd_addr_o),
    .rd_valid_o   (rd_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cur_seg_o    (cur_seg_o)
  );

  typedef struct packed {
    logic           vld;
    logic [DS:0]    addr;
    logic [SIW-1:0] seg;
    logic           busy;
    logic           done;
  } obs_t;

  obs_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic obs_t mk(logic v, int a, int s, logic b, logic d);
    obs_t r;
    r.vld  = v;
    r.addr = a[DS:0];
    r.seg  = s[SIW-1:0];
    r.busy = b;
    r.done = d;
    return r;
  endfunction

  task automatic push_idle();
    sb.push_back(mk(1'b0, 0, 0, 1'b0, 1'b0));
  endtask

  task automatic push_done();
    sb.push_back(mk(1'b0, 0, 0, 1'b0, 1'b1));
  endtask

  // Expected addresses of one segment: rep+1 passes of start..stop, wrapping
  task automatic push_seg(int st, int sp, int rep, int seg);
    int a;
    for (int r = 0; r <= rep; r++) begin
      a = st;
      for (int k = 0; k < AMOD; k++) begin
        sb.push_back(mk(1'b1, a, seg, 1'b1, 1'b0));
        if (a == sp) break;
        a = (a + 1) % AMOD;
      end
    end
  endtask

  task automatic cmp_now(string tag);
    obs_t o, e;
    o.vld  = rd_valid_o;
    o.addr = rd_addr_o;
    o.seg  = cur_seg_o;
    o.busy = busy_o;
    o.done = done_o;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s: no expected entry queued, observed vld=%0d addr=%0d", tag, o.vld, o.addr);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        n_err++;
        $error("FAIL %s: observed vld=%0d addr=%0d seg=%0d busy=%0d done=%0d, expected vld=%0d addr=%0d seg=%0d busy=%0d done=%0d",
               tag, o.vld, o.addr, o.seg, o.busy, o.done, e.vld, e.addr, e.seg, e.busy, e.done);
      end
    end
  endtask

  // One clock; pulse inputs are dropped once they have been sampled
  task automatic step(string tag);
    @(posedge clk);
    #1;
    start_i   = 1'b0;
    stop_i    = 1'b0;
    seg_wr_en = 1'b0;
    cmp_now(tag);
  endtask

  task automatic drain(string tag);
    while (sb.size() > 0) step(tag);
  endtask

  task automatic wr(int idx, int st, int sp, int rep, logic last);
    seg_wr_idx   = idx[SIW-1:0];
    seg_wr_start = st[DS:0];
    seg_wr_stop  = sp[DS:0];
    seg_wr_rep   = rep[RW-1:0];
    seg_wr_last  = last;
    seg_wr_en    = 1'b1;
    push_idle();
    step("wr_idle");
  endtask

  // Launch a sequence; with the trigger option an ARM cycle precedes play
  task automatic kick();
    trig_i  = 1'b0;
    start_i = 1'b1;
`ifdef DACOBUF_SEQ_TRIG_EN
    sb.push_back(mk(1'b0, 0, 0, 1'b1, 1'b0));
    step("arm");
    trig_i = 1'b1;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    up_rst = 1'b1; seg_wr_en = 1'b0; seg_wr_idx = '0; seg_wr_start = '0;
    seg_wr_stop = '0; seg_wr_rep = '0; seg_wr_last = 1'b0;
    loop_en = 1'b0; start_i = 1'b0; stop_i = 1'b0; trig_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_idle();
    cmp_now("reset");
    @(negedge clk);
    up_rst = 1'b0;

    // Single segment played twice, start_i while busy ignored
    wr(0, 4, 7, 1, 1'b1);
    loop_en = 1'b0;
    kick();
    push_seg(4, 7, 1, 0); push_done(); push_idle();
    step("t1"); step("t1");
    start_i = 1'b1;
    drain("t1");

    // Two chained segments looping, then stop at a segment end
    wr(0, 0, 1, 0, 1'b0);
    wr(1, 10, 11, 0, 1'b1);
    loop_en = 1'b1;
    kick();
    repeat (3) begin
      push_seg(0, 1, 0, 0);
      push_seg(10, 11, 0, 1);
    end
    drain("t2_loop");
    stop_i = 1'b1;
    push_idle();
    step("t2_stop");
    loop_en = 1'b0;

    // Address wrap inside a segment
    wr(0, 510, 1, 0, 1'b1);
    kick();
    push_seg(510, 1, 0, 0); push_done(); push_idle();
    drain("t3_wrap");

    // start == stop with repeats, then chain
    wr(0, 5, 5, 2, 1'b0);
    wr(1, 7, 8, 0, 1'b1);
    kick();
    push_seg(5, 5, 2, 0); push_seg(7, 8, 0, 1); push_done(); push_idle();
    drain("t4_single");

    // No last flag anywhere: list ends at the final table entry
    wr(0, 1, 1, 0, 1'b0);
    wr(1, 2, 2, 0, 1'b0);
    wr(2, 3, 3, 0, 1'b0);
    wr(3, 4, 4, 0, 1'b0);
    kick();
    for (int s = 0; s < NSEG; s++) push_seg(s + 1, s + 1, 0, s);
    push_done(); push_idle();
    drain("t5_tblend");

    // Rewrite the active entry mid-play; only the reload sees it
    wr(0, 0, 3, 2, 1'b1);
    loop_en = 1'b1;
    kick();
    push_seg(0, 3, 2, 0); push_seg(20, 21, 0, 0); push_seg(20, 21, 0, 0);
    step("t6_play");
    seg_wr_idx = '0; seg_wr_start = 9'd20; seg_wr_stop = 9'd21;
    seg_wr_rep = '0; seg_wr_last = 1'b1; seg_wr_en = 1'b1;
    drain("t6_rewrite");
    stop_i = 1'b1;
    push_idle();
    step("t6_stop");
    loop_en = 1'b0;

`ifdef DACOBUF_SEQ_TRIG_EN
    // Held in ARM until trig_i, then stop_i from ARM
    wr(0, 8, 9, 0, 1'b1);
    trig_i = 1'b0;
    start_i = 1'b1;
    repeat (5) begin
      sb.push_back(mk(1'b0, 0, 0, 1'b1, 1'b0));
      step("t7_arm_hold");
    end
    trig_i = 1'b1;
    push_seg(8, 9, 0, 0); push_done(); push_idle();
    drain("t7_trig");
    trig_i = 1'b0;
    start_i = 1'b1;
    sb.push_back(mk(1'b0, 0, 0, 1'b1, 1'b0));
    step("t7_arm");
    stop_i = 1'b1;
    push_idle();
    step("t7_arm_stop");
`else
    // trig_i has no effect without the trigger option
    trig_i = 1'b1;
    repeat (3) begin
      push_idle();
      step("t7_trig_ignored");
    end
    trig_i = 1'b0;
`endif

    // Asynchronous reset mid-play clears outputs and table
    wr(0, 30, 40, 0, 1'b1);
    kick();
    sb.push_back(mk(1'b1, 30, 0, 1'b1, 1'b0));
    sb.push_back(mk(1'b1, 31, 0, 1'b1, 1'b0));
    step("t8_play"); step("t8_play");
    #1 up_rst = 1'b1;
    #1;
    push_idle();
    cmp_now("t8_async_rst");
    @(negedge clk);
    up_rst  = 1'b0;
    start_i = 1'b1;
    stop_i  = 1'b1;
    push_idle();
    step("t8_start_stop");
    kick();
    for (int s = 0; s < NSEG; s++) push_seg(0, 0, 0, s);
    push_done(); push_idle();
    drain("t8_cleared_tbl");

    n_vec++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL sb_empty: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
